line_fill_master: RTL and testbench
===================================

Name: line_fill_master

Overview:
- Initiator side of the cache-line memory protocol (mem_req_* / mem_resp_*).
- Sits between the cache miss logic and main memory.
- Accepts one miss command at a time. If the victim line is dirty, it first issues a write-line for it, then issues a read-line for the missing line.
- Waits for the response, with a timeout, and returns the fetched line to the cache as a single-cycle fill pulse.

Parameters:
ADDR_W, 32, byte address width
LINE_BYTES, 128, bytes per cache line
LINE_W, LINE_BYTES*8, line data width in bits
TIMEOUT_CYC, 64, maximum cycles to wait in RD_WAIT before declaring an error
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
miss_valid  in  1  cache presents a miss command
miss_ready  out  1  high only in IDLE
miss_addr  in  ADDR_W  byte address of the missing line
miss_wb  in  1  victim is dirty and must be written back first
miss_wb_addr  in  ADDR_W  byte address of the victim line
miss_wb_line  in  LINE_W  victim line data
fill_valid  out  1  one-cycle pulse: fill result available
fill_addr  out  ADDR_W  line-aligned address of the filled line
fill_line  out  LINE_W  fetched data; all zeros on error
fill_err  out  1  qualifies fill_valid: response timed out
busy  out  1  high whenever state is not IDLE
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts the request
mem_req_rw  out  1  0 = read line, 1 = write line
mem_req_addr  out  ADDR_W  line-aligned byte address
mem_req_wline  out  LINE_W  write data; valid when rw=1
mem_resp_valid  in  1  read response pulse
mem_resp_rline  in  LINE_W  read data
stat_fills  out  CNT_W  count of successful fills, saturating
stat_wbs  out  CNT_W  count of completed writebacks, saturating
stat_timeouts  out  CNT_W  count of timeouts, saturating

Behaviour:
- Reset values: state=IDLE; every output and every internal register is 0. The one exception is miss_ready, which is combinational and therefore reads 1 in the first cycle after reset.
- Reset asserted mid-operation abandons the transaction immediately. No fill is produced.
- Address capture: on miss_valid && miss_ready, register addr, wb flag, wb_addr and wb_line. The low $clog2(LINE_BYTES) bits of both addresses are forced to 0 at capture.
- States: IDLE, WB_REQ, RD_REQ, RD_WAIT, DONE.
- IDLE
  - miss_ready=1.
  - On handshake: go to WB_REQ if miss_wb=1, else RD_REQ.
  - The first mem request appears in the cycle after acceptance.
- WB_REQ
  - mem_req_valid=1, rw=1, addr=wb_addr, wline=wb_line.
  - Hold all of these stable until mem_req_ready=1.
  - On handshake: stat_wbs++ and go to RD_REQ.
  - No response is expected for writes.
- RD_REQ
  - mem_req_valid=1, rw=0, addr=miss addr, wline driven to 0.
  - Hold stable until ready.
  - On handshake: clear the timer and go to RD_WAIT.
  - Writeback is always ordered strictly before the read, giving at least one cycle of separation.
- RD_WAIT
  - mem_req_valid=0.
  - Timer increments each cycle.
  - If mem_resp_valid: capture rline and go to DONE with err=0. This takes precedence over the timer if both happen in the same cycle.
  - Else if timer == TIMEOUT_CYC-1: go to DONE with err=1 and line=0.
- DONE
  - fill_valid=1 for exactly one cycle, with fill_addr, fill_line and fill_err stable in that cycle.
  - stat_fills++ if err=0, else stat_timeouts++.
  - Next state is IDLE.
  - There is no ready from the cache: fill must be consumed in that cycle.
- fill_valid is asserted exactly one cycle after the cycle in which mem_resp_valid is sampled high.
- mem_resp_valid outside RD_WAIT is ignored. This covers stray responses and late responses arriving after a timeout.
- Counters saturate at 2^CNT_W-1 and never wrap.
- A new miss can be accepted in the IDLE cycle immediately following DONE. The minimum miss-to-miss spacing with no writeback and a zero-latency response is 4 cycles.

Decomposition:
- Shared package line_mem_pkg holds:
  - state enum fill_state_e;
  - localparams OFFSET_BITS = $clog2(LINE_BYTES) and the RW_READ/RW_WRITE encodings;
  - line_align() function.
- One natural sub-module: sat_counter (parameter CNT_W; inputs clk, rst, inc; output value), instantiated three times.
- The FSM and datapath stay in the top module.

Test Plan:
- Clean miss, no writeback: miss_addr=0x1234_5678, responder latency 5, line 0xA5 pattern.
  - mem_req sees rw=0, addr=0x1234_5600.
  - One fill_valid pulse: fill_line=pattern, fill_err=0, stat_fills=1.
- Dirty miss: miss_wb=1, wb_addr=0x0000_0180, wb_line=0x5A pattern, miss_addr=0x0000_0280.
  - Write (rw=1, 0x180) is observed before the read (rw=0, 0x280).
  - Peeking memory at 0x180 returns the 0x5A pattern; stat_wbs=1.
- Backpressure: hold mem_req_ready low for 7 cycles during WB_REQ and during RD_REQ.
  - addr, rw and wline are stable throughout each stall.
  - Exactly one write and one read are accepted.
- Timeout: responder never answers.
  - fill_valid with fill_err=1 and fill_line=0 occurs TIMEOUT_CYC cycles after the read handshake; stat_timeouts=1.
  - A late mem_resp_valid injected afterwards produces no fill.
- Reset mid-RD_WAIT: assert rst for 1 cycle.
  - All outputs are 0 and miss_ready=1 on release.
  - The subsequent response is ignored and there is no fill_valid.
- Back-to-back: 300 random misses (30% dirty) against the memory model.
  - Every fill matches the model contents.
  - No request is issued while another is outstanding, and miss_ready never rises while busy=1.

Source files
------------

// File: rtl/line_mem_pkg.sv
// rtl/line_mem_pkg.sv - shared types, encodings and helpers for the line fill master
//
// Purpose: state encoding, read/write encodings and line alignment shared by
// the line fill master and its bench.
package line_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DONE
  } fill_state_e;

  localparam int          LINE_BYTES_DEF = 128;
  localparam int unsigned OFFSET_BITS    = $clog2(LINE_BYTES_DEF);

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Clears the byte-offset bits so the address points at the start of its line.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned off_bits = OFFSET_BITS);
    logic [63:0] mask;
    mask = (64'd1 << off_bits) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
//
// Purpose: counts single-cycle inc pulses and sticks at all-ones.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the count
//   inc   - count one event this cycle
//   value - current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (inc && (value_q != {CNT_W{1'b1}})) begin
      value_q <= value_q + CNT_W'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/line_fill_master.sv
// rtl/line_fill_master.sv - cache line fill initiator with optional writeback and timeout
//
// Purpose: accepts one miss at a time, writes back a dirty victim first, reads
// the missing line, waits for the response with a timeout and returns the line
// to the cache as a one-cycle fill pulse.
// Ports:
//   clk, rst                          - clock and synchronous active-high reset
//   miss_valid/ready/addr/wb/wb_addr/wb_line - miss command from the cache
//   fill_valid/addr/line/err          - one-cycle fill result to the cache
//   busy                              - a miss is in progress
//   mem_req_valid/ready/rw/addr/wline - line request to memory
//   mem_resp_valid/rline              - read response from memory
//   stat_fills/wbs/timeouts           - saturating statistics
module line_fill_master
  import line_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LINE_BYTES  = LINE_BYTES_DEF,
  parameter int LINE_W      = LINE_BYTES * 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              miss_wb,
  input  logic [ADDR_W-1:0] miss_wb_addr,
  input  logic [LINE_W-1:0] miss_wb_line,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_line,
  output logic              fill_err,
  output logic              busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wline,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_rline,
  output logic [CNT_W-1:0]  stat_fills,
  output logic [CNT_W-1:0]  stat_wbs,
  output logic [CNT_W-1:0]  stat_timeouts
);

  localparam int unsigned OFF_BITS = $clog2(LINE_BYTES);
  localparam int          TMR_W    = $clog2(TIMEOUT_CYC + 1);

  fill_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TMR_W-1:0]  timer_q;
  logic              busy_q;
  logic              req_valid_q;
  logic              req_rw_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [LINE_W-1:0] req_wline_q;
  logic              fill_valid_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [LINE_W-1:0] fill_line_q;
  logic              fill_err_q;

  logic [ADDR_W-1:0] miss_addr_al;
  logic [ADDR_W-1:0] wb_addr_al;
  logic              wb_done;
  logic              fill_ok;
  logic              fill_to;

  assign miss_addr_al = ADDR_W'(line_align(64'(miss_addr), OFF_BITS));
  assign wb_addr_al   = ADDR_W'(line_align(64'(miss_wb_addr), OFF_BITS));

  // The victim address and data live directly in the request registers, so
  // the writeback request is already presented the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      req_rw_q     <= RW_READ;
      req_addr_q   <= '0;
      req_wline_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_line_q  <= '0;
      fill_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_valid) begin
            addr_q      <= miss_addr_al;
            busy_q      <= 1'b1;
            req_valid_q <= 1'b1;
            if (miss_wb) begin
              state_q     <= ST_WB_REQ;
              req_rw_q    <= RW_WRITE;
              req_addr_q  <= wb_addr_al;
              req_wline_q <= miss_wb_line;
            end else begin
              state_q     <= ST_RD_REQ;
              req_rw_q    <= RW_READ;
              req_addr_q  <= miss_addr_al;
              req_wline_q <= '0;
            end
          end
        end
        ST_WB_REQ: begin
          if (mem_req_ready) begin
            state_q     <= ST_RD_REQ;
            req_rw_q    <= RW_READ;
            req_addr_q  <= addr_q;
            req_wline_q <= '0;
          end
        end
        ST_RD_REQ: begin
          if (mem_req_ready) begin
            state_q     <= ST_RD_WAIT;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            timer_q     <= '0;
          end
        end
        ST_RD_WAIT: begin
          timer_q <= timer_q + TMR_W'(1);
          // A response in the last timer cycle still wins over the timeout.
          if (mem_resp_valid) begin
            state_q      <= ST_DONE;
            fill_valid_q <= 1'b1;
            fill_addr_q  <= addr_q;
            fill_line_q  <= mem_resp_rline;
            fill_err_q   <= 1'b0;
          end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            state_q      <= ST_DONE;
            fill_valid_q <= 1'b1;
            fill_addr_q  <= addr_q;
            fill_line_q  <= '0;
            fill_err_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          fill_valid_q <= 1'b0;
          fill_addr_q  <= '0;
          fill_line_q  <= '0;
          fill_err_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign miss_ready    = (state_q == ST_IDLE);
  assign busy          = busy_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_rw    = req_rw_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wline = req_wline_q;
  assign fill_valid    = fill_valid_q;
  assign fill_addr     = fill_addr_q;
  assign fill_line     = fill_line_q;
  assign fill_err      = fill_err_q;

  assign wb_done = (state_q == ST_WB_REQ) && mem_req_ready;
  assign fill_ok = fill_valid_q && !fill_err_q;
  assign fill_to = fill_valid_q && fill_err_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_fills (
    .clk   (clk),
    .rst   (rst),
    .inc   (fill_ok),
    .value (stat_fills)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_wbs (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_done),
    .value (stat_wbs)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_timeouts (
    .clk   (clk),
    .rst   (rst),
    .inc   (fill_to),
    .value (stat_timeouts)
  );

endmodule

// File: tb/tb_line_fill_master.sv
// tb/tb_line_fill_master.sv - scoreboard bench for line_fill_master
module tb_line_fill_master;

  localparam int ADDR_W      = 32;
  localparam int LINE_BYTES  = 128;
  localparam int LINE_W      = LINE_BYTES * 8;
  localparam int TIMEOUT_CYC = 64;
  localparam int CNT_W       = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef struct { logic rw; addr_t addr; line_t wline; } req_t;
  typedef struct { addr_t addr; logic err; line_t line; } fill_t;
  typedef struct { int due; line_t data; } resp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             miss_valid, miss_ready, miss_wb;
  addr_t            miss_addr, miss_wb_addr, fill_addr, mem_req_addr;
  line_t            miss_wb_line, fill_line, mem_req_wline, mem_resp_rline;
  logic             fill_valid, fill_err, busy;
  logic             mem_req_valid, mem_req_ready, mem_req_rw, mem_resp_valid;
  logic [CNT_W-1:0] stat_fills, stat_wbs, stat_timeouts;

  line_fill_master dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_wb(miss_wb), .miss_wb_addr(miss_wb_addr), .miss_wb_line(miss_wb_line),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line),
    .fill_err(fill_err), .busy(busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_wline(mem_req_wline),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rline(mem_resp_rline),
    .stat_fills(stat_fills), .stat_wbs(stat_wbs), .stat_timeouts(stat_timeouts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  req_t  exp_req[$];
  fill_t exp_fill[$];
  resp_t sched[$];
  line_t ref_mem[addr_t];
  line_t rsp_mem[addr_t];

  int lat_min = 0, lat_max = 0, rdy_mode = 0;
  bit no_resp = 0;
  bit rd_out = 0;
  int rd_hs_cyc = 0, resp_cyc = -1, n_wr = 0, n_rd = 0, acc_cyc = 0;
  int exp_fills = 0, exp_wbs = 0, exp_to = 0;

  function automatic addr_t align(input addr_t a);
    return a & ~addr_t'(LINE_BYTES - 1);
  endfunction

  function automatic line_t init_line(input addr_t a);
    line_t l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = a ^ (32'(i) * 32'h9E37_79B9);
    return l;
  endfunction

  function automatic line_t pat(input logic [7:0] b);
    return {LINE_BYTES{b}};
  endfunction

  function automatic line_t rnd_line();
    line_t l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic line_t ref_get(input addr_t a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  function automatic line_t rsp_get(input addr_t a);
    if (rsp_mem.exists(a)) return rsp_mem[a];
    return init_line(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual[127:0]=0x%0h expected[127:0]=0x%0h", nm, act[127:0], exp[127:0]);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s bound expired or event not expected", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  initial begin : monitor
    req_t  r;
    fill_t f;
    logic  prev_v, prev_r, prev_rw;
    addr_t prev_addr;
    line_t prev_wline;
    prev_v = 1'b0; prev_r = 1'b0; prev_rw = 1'b0; prev_addr = '0; prev_wline = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        continue;
      end
      chk("ready_while_busy", 64'(miss_ready && busy), 64'd0);
      if (prev_v && !prev_r) begin
        chk("stall_valid", 64'(mem_req_valid), 64'd1);
        chk("stall_rw", 64'(mem_req_rw), 64'(prev_rw));
        chk("stall_addr", 64'(mem_req_addr), 64'(prev_addr));
        chk_line("stall_wline", mem_req_wline, prev_wline);
      end
      if (mem_req_valid) chk("req_while_outstanding", 64'(rd_out), 64'd0);
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          fail("unexpected_req");
        end else begin
          r = exp_req.pop_front();
          chk("req_rw", 64'(mem_req_rw), 64'(r.rw));
          chk("req_addr", 64'(mem_req_addr), 64'(r.addr));
          chk_line("req_wline", mem_req_wline, r.wline);
        end
        if (mem_req_rw) begin
          rsp_mem[mem_req_addr] = mem_req_wline;
          n_wr++;
        end else begin
          n_rd++;
          rd_out = 1'b1;
          rd_hs_cyc = cyc;
          resp_cyc = -1;
          if (!no_resp)
            sched.push_back('{cyc + 1 + int'($urandom_range(lat_max, lat_min)),
                              rsp_get(mem_req_addr)});
        end
      end
      if (mem_resp_valid && rd_out && resp_cyc < 0) resp_cyc = cyc;
      if (fill_valid) begin
        if (exp_fill.size() == 0) begin
          fail("unexpected_fill");
        end else begin
          f = exp_fill.pop_front();
          chk("fill_addr", 64'(fill_addr), 64'(f.addr));
          chk("fill_err", 64'(fill_err), 64'(f.err));
          chk_line("fill_line", fill_line, f.line);
          if (resp_cyc >= 0) chk("fill_latency", 64'(cyc - resp_cyc), 64'd1);
          else chk("timeout_latency", 64'(cyc - (rd_hs_cyc + 1)), 64'(TIMEOUT_CYC));
        end
        rd_out = 1'b0;
        resp_cyc = -1;
      end
      prev_v = mem_req_valid; prev_r = mem_req_ready; prev_rw = mem_req_rw;
      prev_addr = mem_req_addr; prev_wline = mem_req_wline;
    end
  end

  // Memory responder: plays scheduled read responses.
  initial begin : responder
    resp_t s;
    mem_resp_valid = 1'b0;
    mem_resp_rline = '0;
    forever begin
      step();
      mem_resp_valid = 1'b0;
      mem_resp_rline = '0;
      if (sched.size() > 0 && sched[0].due <= cyc) begin
        s = sched.pop_front();
        mem_resp_valid = 1'b1;
        mem_resp_rline = s.data;
      end
    end
  end

  // Request acceptor: always ready, random, or 7-cycle stall per request.
  initial begin : acceptor
    int stall;
    stall = 0;
    mem_req_ready = 1'b0;
    forever begin
      step();
      case (rdy_mode)
        0: mem_req_ready = 1'b1;
        1: mem_req_ready = 1'($urandom_range(1, 0));
        default: begin
          if (!mem_req_valid) begin
            mem_req_ready = 1'b0; stall = 0;
          end else if (stall < 7) begin
            mem_req_ready = 1'b0; stall++;
          end else begin
            mem_req_ready = 1'b1; stall = 0;
          end
        end
      endcase
    end
  end

  task automatic issue(input addr_t a, input bit wb, input addr_t wa, input line_t wl);
    fill_t f;
    int n;
    n = 0;
    while (!miss_ready) begin
      step();
      n++;
      if (n > 500) begin fail("miss_ready_wait"); return; end
    end
    acc_cyc = cyc;
    miss_valid = 1'b1; miss_addr = a; miss_wb = wb; miss_wb_addr = wa; miss_wb_line = wl;
    if (wb) begin
      exp_req.push_back('{1'b1, align(wa), wl});
      ref_mem[align(wa)] = wl;
      exp_wbs++;
    end
    exp_req.push_back('{1'b0, align(a), '0});
    f.addr = align(a);
    f.err  = no_resp;
    f.line = no_resp ? '0 : ref_get(align(a));
    exp_fill.push_back(f);
    if (no_resp) exp_to++; else exp_fills++;
    step();
    miss_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy || exp_fill.size() != 0) begin
      step();
      n++;
      if (n > 1000) begin
        fail("idle_wait");
        exp_fill.delete();
        exp_req.delete();
        return;
      end
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_stat_fills"}, 64'(stat_fills), 64'(exp_fills));
    chk({tag, "_stat_wbs"}, 64'(stat_wbs), 64'(exp_wbs));
    chk({tag, "_stat_timeouts"}, 64'(stat_timeouts), 64'(exp_to));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({fill_valid, fill_err, busy, mem_req_valid, mem_req_rw}), 64'd0);
    chk({tag, "_fill_addr"}, 64'(fill_addr), 64'd0);
    chk({tag, "_req_addr"}, 64'(mem_req_addr), 64'd0);
    chk_line({tag, "_fill_line"}, fill_line, '0);
    chk_line({tag, "_req_wline"}, mem_req_wline, '0);
    chk({tag, "_stats"}, 64'({stat_fills, stat_wbs, stat_timeouts}), 64'd0);
    chk({tag, "_miss_ready"}, 64'(miss_ready), 64'd1);
  endtask

  initial begin : main
    int t1, n;
    addr_t a, wa;
    bit wb;
    rst = 1'b1;
    miss_valid = 1'b0; miss_addr = '0; miss_wb = 1'b0; miss_wb_addr = '0; miss_wb_line = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset("reset");

    // Clean miss, responder latency 5, 0xA5 line.
    lat_min = 5; lat_max = 5; rdy_mode = 0;
    rsp_mem[32'h1234_5600] = pat(8'hA5);
    ref_mem[32'h1234_5600] = pat(8'hA5);
    issue(32'h1234_5678, 1'b0, '0, '0);
    wait_idle();
    chk_stats("clean");

    // Dirty miss: writeback then read.
    issue(32'h0000_0280, 1'b1, 32'h0000_0180, pat(8'h5A));
    wait_idle();
    chk_line("peek_0x180", rsp_get(32'h0000_0180), pat(8'h5A));
    chk_stats("dirty");

    // Backpressure on both requests.
    rdy_mode = 2; n_wr = 0; n_rd = 0;
    issue(32'h0000_3344, 1'b1, 32'h0000_5566, rnd_line());
    wait_idle();
    chk("bp_writes", 64'(n_wr), 64'd1);
    chk("bp_reads", 64'(n_rd), 64'd1);
    rdy_mode = 0;

    // Minimum miss-to-miss spacing with zero-latency responses.
    lat_min = 0; lat_max = 0;
    issue(32'h0000_0900, 1'b0, '0, '0);
    t1 = acc_cyc;
    issue(32'h0000_0A00, 1'b0, '0, '0);
    chk("miss_spacing", 64'(acc_cyc - t1), 64'd4);
    wait_idle();
    chk_stats("spacing");

    // Timeout, then a late response that must be ignored.
    no_resp = 1'b1;
    issue(32'h0000_4000, 1'b0, '0, '0);
    wait_idle();
    no_resp = 1'b0;
    sched.push_back('{cyc + 2, pat(8'hFF)});
    repeat (10) step();
    chk_stats("timeout");

    // Reset in the middle of RD_WAIT.
    lat_min = 20; lat_max = 20;
    issue(32'h0000_8000, 1'b0, '0, '0);
    n = 0;
    while (!rd_out && n < 200) begin step(); n++; end
    chk("rd_wait_reached", 64'(rd_out), 64'd1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_fill.delete(); exp_req.delete();
    rd_out = 1'b0; resp_cyc = -1;
    exp_fills = 0; exp_wbs = 0; exp_to = 0;
    chk_reset("midreset");
    repeat (30) step();
    chk_stats("after_reset");

    // 300 random back-to-back misses, 30% dirty.
    lat_min = 0; lat_max = 8;
    for (int i = 0; i < 300; i++) begin
      rdy_mode = ($urandom_range(3, 0) == 0) ? 0 : 1;
      a  = addr_t'(32'h1000_0000 | ($urandom_range(15, 0) << 7) | $urandom_range(127, 0));
      wa = addr_t'(32'h1000_0000 | ($urandom_range(15, 0) << 7) | $urandom_range(127, 0));
      wb = ($urandom_range(99, 0) < 30);
      issue(a, wb, wa, rnd_line());
    end
    wait_idle();
    chk_stats("random");
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
